tdt_dtm_apbm: RTL and testbench

- APB master stage directly downstream of the DTM's DMI request interface.
- Accepts one DMI read/write request at a time from the DTM, runs it as an APB3 transfer to the debug module register file, and returns read data.
- Runs on the DTM clock, so no CDC; the DTM sees only the ready/rdata pair.

---
 rtl/tdt_dtm_apbm_if.sv | 60 ++++++
 rtl/tdt_dtm_apbm.sv | 134 +++++++++++++
 tb/tb_tdt_dtm_apbm.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tdt_dtm_apbm_if.sv
// tdt_dtm_apbm_if: DMI request side and APB3 side of the DTM APB master.
// master = the APB master stage, slave = DTM plus debug-module register file.
interface tdt_dtm_apbm_if #(
  parameter int AW = 16
);
  logic          dmihardreset;
  logic          dtm_apbm_wr_vld;
  logic [AW-1:0] dtm_apbm_wr_addr;
  logic [1:0]    dtm_apbm_wr_flg;
  logic [31:0]   dtm_apbm_wdata;
  logic          apbm_dtm_wr_ready;
  logic [31:0]   apbm_dtm_rdata;
  logic          apbm_dtm_err;
  logic          apbm_psel;
  logic          apbm_penable;
  logic          apbm_pwrite;
  logic [AW+1:0] apbm_paddr;
  logic [31:0]   apbm_pwdata;
  logic [31:0]   apbm_prdata;
  logic          apbm_pready;
  logic          apbm_pslverr;

  modport master (
    input  dmihardreset,
    input  dtm_apbm_wr_vld,
    input  dtm_apbm_wr_addr,
    input  dtm_apbm_wr_flg,
    input  dtm_apbm_wdata,
    output apbm_dtm_wr_ready,
    output apbm_dtm_rdata,
    output apbm_dtm_err,
    output apbm_psel,
    output apbm_penable,
    output apbm_pwrite,
    output apbm_paddr,
    output apbm_pwdata,
    input  apbm_prdata,
    input  apbm_pready,
    input  apbm_pslverr
  );

  modport slave (
    output dmihardreset,
    output dtm_apbm_wr_vld,
    output dtm_apbm_wr_addr,
    output dtm_apbm_wr_flg,
    output dtm_apbm_wdata,
    input  apbm_dtm_wr_ready,
    input  apbm_dtm_rdata,
    input  apbm_dtm_err,
    input  apbm_psel,
    input  apbm_penable,
    input  apbm_pwrite,
    input  apbm_paddr,
    input  apbm_pwdata,
    output apbm_prdata,
    output apbm_pready,
    output apbm_pslverr
  );
endinterface

// File: rtl/tdt_dtm_apbm.sv
// tdt_dtm_apbm: runs one DMI read/write at a time as an APB3 transfer.
// Ports: tclk, trst_b (async low), bus (tdt_dtm_apbm_if.master).
// Optional macro TDT_DTM_APBM_TIMEOUT_EN adds an ACCESS wait limit.
module tdt_dtm_apbm #(
  parameter int DTM_ABITS   = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input logic            tclk,
  input logic            trst_b,
  tdt_dtm_apbm_if.master bus
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_to
    $error("TIMEOUT_CYC must be 1..255");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DTM_ABITS+1:0] paddr_q;
  logic [31:0]          pwdata_q;
  logic                 pwrite_q;
  logic                 rd_q;
  logic [31:0]          rdata_q;
  logic                 err_q;
  logic                 drop_q;

  logic ready;
  logic accept;
  logic is_rd;
  logic is_wr;
  logic start;
  logic done;
  logic tmo;
  logic fin;
  logic discard;

  assign is_rd  = bus.dtm_apbm_wr_flg == 2'b01;
  assign is_wr  = bus.dtm_apbm_wr_flg == 2'b10;
  assign accept = bus.dtm_apbm_wr_vld & ready;
  assign start  = accept & (is_rd | is_wr);
  assign done   = (state_q == ACCESS) & bus.apbm_pready;
  assign fin    = done | tmo;
  // A hard reset seen during the transfer discards its result.
  assign discard = drop_q | bus.dmihardreset;

`ifdef TDT_DTM_APBM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt_q;

  assign tmo = (state_q == ACCESS) & ~bus.apbm_pready
             & (cnt_q == TO_LAST);

  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      cnt_q <= 8'd0;
    end else if (state_q == SETUP) begin
      cnt_q <= 8'd0;
    end else if (state_q == ACCESS && !bus.apbm_pready) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (fin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready            = (state_q == IDLE) & ~bus.dmihardreset;
    bus.apbm_psel    = state_q != IDLE;
    bus.apbm_penable = state_q == ACCESS;
  end

  always_ff @(posedge tclk or negedge trst_b) begin
    if (!trst_b) begin
      paddr_q  <= '0;
      pwdata_q <= 32'h0;
      pwrite_q <= 1'b0;
      rd_q     <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      if (start) begin
        paddr_q  <= {bus.dtm_apbm_wr_addr, 2'b00};
        pwdata_q <= bus.dtm_apbm_wdata;
        pwrite_q <= is_wr;
        rd_q     <= is_rd;
      end else if (fin) begin
        pwrite_q <= 1'b0;
      end

      if (state_q == IDLE)       drop_q <= 1'b0;
      else if (bus.dmihardreset) drop_q <= 1'b1;

      if (done && rd_q && !discard)     rdata_q <= bus.apbm_prdata;
      else if (tmo && rd_q && !discard) rdata_q <= 32'h0;

      if (bus.dmihardreset) begin
        err_q <= 1'b0;
      end else if (!drop_q &&
                   ((done && bus.apbm_pslverr) || tmo)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.apbm_dtm_wr_ready = ready;
  assign bus.apbm_dtm_rdata    = rdata_q;
  assign bus.apbm_dtm_err      = err_q;
  assign bus.apbm_pwrite       = pwrite_q;
  assign bus.apbm_paddr        = paddr_q;
  assign bus.apbm_pwdata       = pwdata_q;

endmodule

// File: tb/tb_tdt_dtm_apbm.sv
// tb_tdt_dtm_apbm: directed bench for the DTM APB master.
// Expected completions queue in a scoreboard and are popped on ready.
module tb_tdt_dtm_apbm;

  logic tclk   = 1'b0;
  logic trst_b = 1'b0;
  int   n_chk  = 0;
  int   n_err  = 0;

  always #5 tclk = ~tclk;

  tdt_dtm_apbm_if #(.AW(16)) bus();

  tdt_dtm_apbm #(
    .DTM_ABITS  (16),
    .TIMEOUT_CYC(4)
  ) dut (
    .tclk  (tclk),
    .trst_b(trst_b),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  task automatic tick();
    @(posedge tclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] r, input logic e,
                      input int l);
    exp_t x;
    x.rdata = r;
    x.err   = e;
    x.lat   = l;
    sb.push_back(x);
  endtask

  task automatic issue(input logic [1:0] f, input logic [15:0] a,
                       input logic [31:0] d);
    bus.dtm_apbm_wr_vld  = 1'b1;
    bus.dtm_apbm_wr_flg  = f;
    bus.dtm_apbm_wr_addr = a;
    bus.dtm_apbm_wdata   = d;
    tick();
    bus.dtm_apbm_wr_vld = 1'b0;
    bus.dtm_apbm_wr_flg = 2'b00;
  endtask

  task automatic wait_done(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (bus.apbm_dtm_wr_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_rdy"}, 32'(bus.apbm_dtm_wr_ready), 32'd1);
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $error("FAIL %s_sb: observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, bus.apbm_dtm_rdata, e.rdata);
      chk({tag, "_err"}, 32'(bus.apbm_dtm_err), 32'(e.err));
      chk({tag, "_lat"}, n, e.lat);
      chk({tag, "_psel"}, 32'(bus.apbm_psel), 32'd0);
    end
  endtask

  initial begin
    bus.dmihardreset     = 1'b0;
    bus.dtm_apbm_wr_vld  = 1'b0;
    bus.dtm_apbm_wr_addr = 16'h0;
    bus.dtm_apbm_wr_flg  = 2'b00;
    bus.dtm_apbm_wdata   = 32'h0;
    bus.apbm_prdata      = 32'h0;
    bus.apbm_pready      = 1'b0;
    bus.apbm_pslverr     = 1'b0;

    // reset values
    tick();
    tick();
    chk("rst_ready", 32'(bus.apbm_dtm_wr_ready), 32'd1);
    chk("rst_psel", 32'(bus.apbm_psel), 32'd0);
    chk("rst_pen", 32'(bus.apbm_penable), 32'd0);
    chk("rst_pwrite", 32'(bus.apbm_pwrite), 32'd0);
    chk("rst_paddr", 32'(bus.apbm_paddr), 32'h0);
    chk("rst_pwdata", bus.apbm_pwdata, 32'h0);
    chk("rst_rdata", bus.apbm_dtm_rdata, 32'h0);
    chk("rst_err", 32'(bus.apbm_dtm_err), 32'd0);
    trst_b = 1'b1;
    tick();

    // read, pready immediately
    bus.apbm_prdata = 32'hA5A5_0001;
    bus.apbm_pready = 1'b1;
    issue(2'b01, 16'h0011, 32'h0);
    chk("rd_setup_psel", 32'(bus.apbm_psel), 32'd1);
    chk("rd_setup_pen", 32'(bus.apbm_penable), 32'd0);
    chk("rd_setup_paddr", 32'(bus.apbm_paddr), 32'h00044);
    chk("rd_setup_pwrite", 32'(bus.apbm_pwrite), 32'd0);
    chk("rd_setup_ready", 32'(bus.apbm_dtm_wr_ready), 32'd0);
    push(32'hA5A5_0001, 1'b0, 1);
    tick();
    chk("rd_acc_pen", 32'(bus.apbm_penable), 32'd1);
    chk("rd_acc_psel", 32'(bus.apbm_psel), 32'd1);
    wait_done("rd1");

    // write with three wait states
    bus.apbm_pready = 1'b0;
    issue(2'b10, 16'h0010, 32'h8000_0001);
    chk("wr_setup_pwrite", 32'(bus.apbm_pwrite), 32'd1);
    chk("wr_setup_paddr", 32'(bus.apbm_paddr), 32'h00040);
    chk("wr_setup_pwdata", bus.apbm_pwdata, 32'h8000_0001);
    push(32'hA5A5_0001, 1'b0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("wr_acc_psel", 32'(bus.apbm_psel), 32'd1);
      chk("wr_acc_pen", 32'(bus.apbm_penable), 32'd1);
      chk("wr_acc_pwrite", 32'(bus.apbm_pwrite), 32'd1);
      chk("wr_acc_paddr", 32'(bus.apbm_paddr), 32'h00040);
      chk("wr_acc_pwdata", bus.apbm_pwdata, 32'h8000_0001);
      chk("wr_acc_ready", 32'(bus.apbm_dtm_wr_ready), 32'd0);
      chk("wr_acc_rdata", bus.apbm_dtm_rdata, 32'hA5A5_0001);
      if (i == 3) bus.apbm_pready = 1'b1;
      tick();
    end
    wait_done("wr1");
    chk("wr_pwrite_clr", 32'(bus.apbm_pwrite), 32'd0);

    // nop then back-to-back read
    bus.apbm_prdata      = 32'h3C3C_0002;
    bus.dtm_apbm_wr_vld  = 1'b1;
    bus.dtm_apbm_wr_flg  = 2'b00;
    bus.dtm_apbm_wr_addr = 16'h0005;
    tick();
    chk("nop_psel", 32'(bus.apbm_psel), 32'd0);
    chk("nop_ready", 32'(bus.apbm_dtm_wr_ready), 32'd1);
    chk("nop_rdata", bus.apbm_dtm_rdata, 32'hA5A5_0001);
    issue(2'b01, 16'h0006, 32'h0);
    chk("b2b_psel", 32'(bus.apbm_psel), 32'd1);
    chk("b2b_pen", 32'(bus.apbm_penable), 32'd0);
    chk("b2b_paddr", 32'(bus.apbm_paddr), 32'h00018);
    push(32'h3C3C_0002, 1'b0, 1);
    tick();
    chk("b2b_acc_pen", 32'(bus.apbm_penable), 32'd1);
    wait_done("rd2");

    // slave error, sticky across a clean write
    bus.apbm_prdata  = 32'h0000_1234;
    bus.apbm_pslverr = 1'b1;
    issue(2'b01, 16'h0001, 32'h0);
    push(32'h0000_1234, 1'b1, 1);
    tick();
    wait_done("rd_err");
    bus.apbm_pslverr = 1'b0;
    bus.apbm_prdata  = 32'hDEAD_BEEF;
    issue(2'b10, 16'h0002, 32'h0000_0055);
    push(32'h0000_1234, 1'b1, 1);
    tick();
    wait_done("wr_sticky");

    // hard reset in IDLE with a request pending
    bus.dmihardreset    = 1'b1;
    bus.dtm_apbm_wr_vld = 1'b1;
    bus.dtm_apbm_wr_flg = 2'b01;
    #1;
    chk("hr_ready", 32'(bus.apbm_dtm_wr_ready), 32'd0);
    tick();
    bus.dmihardreset    = 1'b0;
    bus.dtm_apbm_wr_vld = 1'b0;
    bus.dtm_apbm_wr_flg = 2'b00;
    chk("hr_err", 32'(bus.apbm_dtm_err), 32'd0);
    chk("hr_noacc", 32'(bus.apbm_psel), 32'd0);
    #1;
    chk("hr_ready_back", 32'(bus.apbm_dtm_wr_ready), 32'd1);
    tick();

    // hard reset mid-ACCESS: complete but discard
    bus.apbm_pready = 1'b0;
    issue(2'b01, 16'h0003, 32'h0);
    tick();
    chk("hrm_acc_pen", 32'(bus.apbm_penable), 32'd1);
    bus.dmihardreset = 1'b1;
    tick();
    bus.dmihardreset = 1'b0;
    chk("hrm_psel", 32'(bus.apbm_psel), 32'd1);
    chk("hrm_pen", 32'(bus.apbm_penable), 32'd1);
    chk("hrm_paddr", 32'(bus.apbm_paddr), 32'h0000C);
    bus.apbm_prdata  = 32'hFFFF_FFFF;
    bus.apbm_pslverr = 1'b1;
    bus.apbm_pready  = 1'b1;
    push(32'h0000_1234, 1'b0, 1);
    wait_done("rd_drop");
    bus.apbm_pslverr = 1'b0;

    // top address bits, then async reset mid-transfer
    bus.apbm_pready = 1'b0;
    issue(2'b01, 16'hFFFF, 32'h0);
    chk("top_paddr", 32'(bus.apbm_paddr), 32'h3FFFC);
    tick();
    trst_b = 1'b0;
    #1;
    chk("arst_psel", 32'(bus.apbm_psel), 32'd0);
    chk("arst_pen", 32'(bus.apbm_penable), 32'd0);
    chk("arst_paddr", 32'(bus.apbm_paddr), 32'h0);
    chk("arst_rdata", bus.apbm_dtm_rdata, 32'h0);
    tick();
    trst_b = 1'b1;
    tick();

`ifdef TDT_DTM_APBM_TIMEOUT_EN
    bus.apbm_prdata = 32'h7777_7777;
    bus.apbm_pready = 1'b0;
    issue(2'b01, 16'h0007, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_acc_pen", 32'(bus.apbm_penable), 32'd1);
      tick();
    end
    chk("to_psel", 32'(bus.apbm_psel), 32'd0);
    chk("to_ready", 32'(bus.apbm_dtm_wr_ready), 32'd1);
    chk("to_err", 32'(bus.apbm_dtm_err), 32'd1);
    chk("to_rdata", bus.apbm_dtm_rdata, 32'h0);
    tick();
    bus.apbm_pready = 1'b1;
    tick();
    tick();
    chk("to_late_psel", 32'(bus.apbm_psel), 32'd0);
    chk("to_late_rdata", bus.apbm_dtm_rdata, 32'h0);
    bus.apbm_pready = 1'b0;
`endif

    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
